// File: rtl/motor_regbank_wdt.sv
// motor_regbank_wdt: bus-slave register bank for the motor drive and encoder logic.
// Holds per-channel setpoints, PWM timing words and mode bits, returns coherent snapshots
// of the encoder counts, and zeroes all setpoints when a command watchdog expires.
// Latency: a write takes effect on the edge that samples it; read data is registered
// (rddata and rd_valid are updated one edge after the read request). No backpressure.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   cs_n, wr_n, rd_n, addr,       processor bus (active-low strobes, word address)
//   wrdata, rddata, rd_valid
//   code_in                       live encoder counts, channel 0 in the low DW bits
//   set_out                       setpoints, channel 0 in the low DW bits
//   pwm_a, pwm_b                  PWM timing words
//   z_openloop, z_brushless       mode selects
//   wdt_trip                      sticky watchdog-tripped flag
module motor_regbank_wdt #(
  parameter int NUM_CH      = 4,
  parameter int DW          = 32,
  parameter int AW          = 5,
  parameter int WDT_TIMEOUT = 50000,
  parameter int PWM_A_RST   = 170,
  parameter int PWM_B_RST   = 100
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cs_n,
  input  logic                 wr_n,
  input  logic                 rd_n,
  input  logic [AW-1:0]        addr,
  input  logic [DW-1:0]        wrdata,
  output logic [DW-1:0]        rddata,
  output logic                 rd_valid,
  input  logic [NUM_CH*DW-1:0] code_in,
  output logic [NUM_CH*DW-1:0] set_out,
  output logic [DW-1:0]        pwm_a,
  output logic [DW-1:0]        pwm_b,
  output logic                 z_openloop,
  output logic                 z_brushless,
  output logic                 wdt_trip
);

  localparam int CW = (WDT_TIMEOUT > 2) ? $clog2(WDT_TIMEOUT) : 1;

  localparam logic [AW-1:0] A_PWMA   = AW'(8);
  localparam logic [AW-1:0] A_PWMB   = AW'(9);
  localparam logic [AW-1:0] A_CTRL   = AW'(10);
  localparam logic [AW-1:0] A_SNAP   = AW'(11);
  localparam logic [AW-1:0] A_STATUS = AW'(12);
  localparam int            CODE_BASE = 16;

  logic [NUM_CH-1:0][DW-1:0] set_q, set_d;
  logic [NUM_CH-1:0][DW-1:0] snap_q, snap_d;
  logic [DW-1:0]             pwma_q, pwma_d;
  logic [DW-1:0]             pwmb_q, pwmb_d;
  logic [DW-1:0]             rddata_q, rddata_d;
  logic                      rdv_q, rdv_d;
  logic                      openloop_q, openloop_d;
  logic                      brushless_q, brushless_d;
  logic                      wdt_en_q, wdt_en_d;
  logic                      trip_q, trip_d;
  logic [CW-1:0]             cnt_q, cnt_d;

  logic          wr_en, rd_en, sp_wr, trip_clr, expire;
  logic [DW-1:0] rd_word;

  // A write always takes priority over a read when both strobes are low.
  assign wr_en = !cs_n && !wr_n;
  assign rd_en = !cs_n && !rd_n && wr_n;

  always_comb begin
    set_d       = set_q;
    snap_d      = snap_q;
    pwma_d      = pwma_q;
    pwmb_d      = pwmb_q;
    openloop_d  = openloop_q;
    brushless_d = brushless_q;
    wdt_en_d    = wdt_en_q;
    sp_wr       = 1'b0;
    trip_clr    = 1'b0;

    if (wr_en) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (addr == AW'(ch)) begin
          set_d[ch] = wrdata;
          sp_wr     = 1'b1;
        end
      end
      case (addr)
        A_PWMA: pwma_d = wrdata;
        A_PWMB: pwmb_d = wrdata;
        A_CTRL: begin
          openloop_d  = wrdata[0];
          brushless_d = wrdata[1];
          wdt_en_d    = wrdata[2];
        end
        // All channels are captured from the same edge so the snapshot is never torn.
        A_SNAP: begin
          for (int ch = 0; ch < NUM_CH; ch++) begin
            snap_d[ch] = code_in[ch*DW +: DW];
          end
        end
        A_STATUS: trip_clr = wrdata[0];
        default: ;
      endcase
    end

    // Expiry is suppressed by a setpoint write on the same edge, so the write wins.
    expire = wdt_en_q && !trip_q && !sp_wr && (cnt_q == CW'(WDT_TIMEOUT - 1));

    if (!wdt_en_q || trip_q || sp_wr || expire) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (expire) begin
      set_d = '0;
    end

    // A status clear on the trip edge wins over the new trip.
    if (trip_clr) begin
      trip_d = 1'b0;
    end else if (expire) begin
      trip_d = 1'b1;
    end else begin
      trip_d = trip_q;
    end
  end

  // Read mux: unmapped addresses and the SNAP trigger read as zero.
  always_comb begin
    rd_word = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (addr == AW'(ch)) begin
        rd_word = set_q[ch];
      end
      if (addr == AW'(CODE_BASE + ch)) begin
        rd_word = snap_q[ch];
      end
    end
    case (addr)
      A_PWMA:   rd_word = pwma_q;
      A_PWMB:   rd_word = pwmb_q;
      A_CTRL:   rd_word = DW'({wdt_en_q, brushless_q, openloop_q});
      A_STATUS: rd_word = DW'(trip_q);
      default: ;
    endcase
    rdv_d    = rd_en;
    rddata_d = rd_en ? rd_word : rddata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_q       <= '0;
      snap_q      <= '0;
      pwma_q      <= DW'(PWM_A_RST);
      pwmb_q      <= DW'(PWM_B_RST);
      rddata_q    <= '0;
      rdv_q       <= 1'b0;
      openloop_q  <= 1'b0;
      brushless_q <= 1'b1;
      wdt_en_q    <= 1'b1;
      trip_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      set_q       <= set_d;
      snap_q      <= snap_d;
      pwma_q      <= pwma_d;
      pwmb_q      <= pwmb_d;
      rddata_q    <= rddata_d;
      rdv_q       <= rdv_d;
      openloop_q  <= openloop_d;
      brushless_q <= brushless_d;
      wdt_en_q    <= wdt_en_d;
      trip_q      <= trip_d;
      cnt_q       <= cnt_d;
    end
  end

  assign set_out     = set_q;
  assign pwm_a       = pwma_q;
  assign pwm_b       = pwmb_q;
  assign z_openloop  = openloop_q;
  assign z_brushless = brushless_q;
  assign wdt_trip    = trip_q;
  assign rddata      = rddata_q;
  assign rd_valid    = rdv_q;

endmodule

// File: tb/tb_motor_regbank_wdt.sv
// tb_motor_regbank_wdt: self-checking bench for motor_regbank_wdt (NUM_CH=4, DW=32, WDT_TIMEOUT=100).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Read expectations go into a queue and are matched against each rd_valid pulse.
module tb_motor_regbank_wdt;

  localparam int NCH = 4;

  logic           clk;
  logic           rst_n;
  logic           cs_n, wr_n, rd_n;
  logic [4:0]     addr;
  logic [31:0]    wrdata;
  logic [31:0]    rddata;
  logic           rd_valid;
  logic [127:0]   code_in;
  logic [127:0]   set_out;
  logic [31:0]    pwm_a, pwm_b;
  logic           z_openloop, z_brushless, wdt_trip;

  motor_regbank_wdt #(
    .NUM_CH(NCH), .DW(32), .AW(5), .WDT_TIMEOUT(100), .PWM_A_RST(170), .PWM_B_RST(100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .addr(addr),
    .wrdata(wrdata), .rddata(rddata), .rd_valid(rd_valid), .code_in(code_in),
    .set_out(set_out), .pwm_a(pwm_a), .pwm_b(pwm_b), .z_openloop(z_openloop),
    .z_brushless(z_brushless), .wdt_trip(wdt_trip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];
  logic [31:0] last_exp = 32'd0;

  typedef struct {
    logic        do_wr;
    logic [4:0]  addr;
    logic [31:0] wdat;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sp(input int ch);
    return set_out[ch*32 +: 32];
  endfunction

  // Scoreboard: every rd_valid pulse must match the oldest outstanding read.
  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rd_valid: rd_valid=1 with no read outstanding, rddata=0x%08h", rddata);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check($sformatf("read_addr_%0d", e.addr), rddata, e.exp);
      end
    end
  end

  task automatic idle_bus();
    cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b1; addr = a; wrdata = d;
    @(negedge clk);
    idle_bus();
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp);
    sb_t e;
    e.addr = a; e.exp = exp;
    sb_q.push_back(e);
    last_exp = exp;
    cs_n = 1'b0; wr_n = 1'b1; rd_n = 1'b0; addr = a;
    @(negedge clk);
    idle_bus();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] snap_exp;

    vecs[0]  = '{1'b1, 5'd2,  32'h0000_1234, 32'h0000_1234};
    vecs[1]  = '{1'b0, 5'd5,  32'h0,         32'h0};
    vecs[2]  = '{1'b1, 5'd8,  32'h0000_A5A5, 32'h0000_A5A5};
    vecs[3]  = '{1'b1, 5'd9,  32'h0000_0055, 32'h0000_0055};
    vecs[4]  = '{1'b1, 5'd10, 32'hFFFF_FFF8, 32'h0};
    vecs[5]  = '{1'b1, 5'd10, 32'hFFFF_FFFF, 32'h7};
    vecs[6]  = '{1'b1, 5'd10, 32'h0000_0006, 32'h6};
    vecs[7]  = '{1'b1, 5'd17, 32'h0000_DEAD, 32'h0};
    vecs[8]  = '{1'b1, 5'd31, 32'h0000_0001, 32'h0};
    vecs[9]  = '{1'b1, 5'd0,  32'h0000_0011, 32'h0000_0011};
    vecs[10] = '{1'b1, 5'd3,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[11] = '{1'b0, 5'd12, 32'h0,         32'h0};
    vecs[12] = '{1'b1, 5'd12, 32'h0000_0001, 32'h0};

    rst_n = 1'b0; idle_bus(); addr = '0; wrdata = '0; code_in = '0;
    repeat (2) @(negedge clk);
    check("rst_pwm_a", pwm_a, 32'd170);
    check("rst_pwm_b", pwm_b, 32'd100);
    check("rst_brushless", {31'd0, z_brushless}, 32'd1);
    check("rst_openloop", {31'd0, z_openloop}, 32'd0);
    check("rst_set_out_or", {31'd0, |set_out}, 32'd0);
    check("rst_trip", {31'd0, wdt_trip}, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_rddata", rddata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Register table: optional write, then read back through the scoreboard.
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].do_wr) wr(vecs[i].addr, vecs[i].wdat);
      rd(vecs[i].addr, vecs[i].exp);
    end
    check("set_out_ch0", sp(0), 32'h11);
    check("set_out_ch2", sp(2), 32'h1234);
    check("set_out_ch3", sp(3), 32'hFFFF_FFFF);
    check("ctrl_brushless", {31'd0, z_brushless}, 32'd1);

    // Watchdog expiry exactly 100 edges after the last setpoint write.
    wr(5'd0, 32'd500);
    check("wdt_set0_written", sp(0), 32'd500);
    repeat (99) @(negedge clk);
    check("wdt_no_trip_at_99", {31'd0, wdt_trip}, 32'd0);
    check("wdt_set0_held_99", sp(0), 32'd500);
    @(negedge clk);
    check("wdt_trip_at_100", {31'd0, wdt_trip}, 32'd1);
    check("wdt_set_out_zero", {31'd0, |set_out}, 32'd0);
    check("wdt_pwm_a_kept", pwm_a, 32'h0000_A5A5);
    check("wdt_pwm_b_kept", pwm_b, 32'h55);
    rd(5'd12, 32'd1);
    rd(5'd0, 32'd0);

    // Setpoint writes still land while tripped; trip stays sticky.
    wr(5'd1, 32'h77);
    check("tripped_set1", sp(1), 32'h77);
    check("tripped_sticky", {31'd0, wdt_trip}, 32'd1);
    wr(5'd12, 32'h0);
    check("status_w0_no_clear", {31'd0, wdt_trip}, 32'd1);
    wr(5'd12, 32'h1);
    check("status_clear", {31'd0, wdt_trip}, 32'd0);

    // A setpoint write on the expiry edge wins, and the count restarts from it.
    wr(5'd0, 32'd500);
    repeat (99) @(negedge clk);
    wr(5'd0, 32'd600);
    check("expiry_edge_write_no_trip", {31'd0, wdt_trip}, 32'd0);
    check("expiry_edge_write_value", sp(0), 32'd600);
    repeat (99) @(negedge clk);
    check("restart_no_trip_99", {31'd0, wdt_trip}, 32'd0);
    @(negedge clk);
    check("restart_trip_100", {31'd0, wdt_trip}, 32'd1);

    // Clear on the same edge as a fresh expiry: clear wins.
    wr(5'd12, 32'h1);
    wr(5'd0, 32'd5);
    repeat (99) @(negedge clk);
    wr(5'd12, 32'h1);
    check("clear_beats_trip", {31'd0, wdt_trip}, 32'd0);

    // Watchdog disabled: no trip however long the bus stays idle.
    wr(5'd10, 32'b010);
    wr(5'd0, 32'd9);
    repeat (1000) @(negedge clk);
    check("wdt_disabled_no_trip", {31'd0, wdt_trip}, 32'd0);
    check("wdt_disabled_set0", sp(0), 32'd9);
    check("ctrl_openloop_0", {31'd0, z_openloop}, 32'd0);
    rd(5'd10, 32'd2);

    // Snapshot while code_in changes every cycle.
    snap_exp = '0;
    for (int i = 0; i < 8; i++) begin
      code_in = {$urandom, $urandom, $urandom, $urandom};
      if (i == 4) begin
        cs_n = 1'b0; wr_n = 1'b0; addr = 5'd11; wrdata = 32'h0;
        snap_exp = code_in;
      end else begin
        idle_bus();
      end
      @(negedge clk);
    end
    idle_bus();
    for (int ch = 0; ch < NCH; ch++) begin
      code_in = {$urandom, $urandom, $urandom, $urandom};
      rd(5'(16 + ch), snap_exp[ch*32 +: 32]);
    end
    rd(5'd11, 32'd0);

    // Write and read strobes together: write only, no read pulse, rddata held.
    cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b0; addr = 5'd8; wrdata = 32'd7;
    @(negedge clk);
    idle_bus();
    check("both_strobes_pwm_a", pwm_a, 32'd7);
    check("both_strobes_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("both_strobes_rddata", rddata, last_exp);

    // Reset in the middle of a write aborts it.
    cs_n = 1'b0; wr_n = 1'b0; addr = 5'd8; wrdata = 32'h99;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pwm_a", pwm_a, 32'd170);
    check("async_rst_set_out", {31'd0, |set_out}, 32'd0);
    @(negedge clk);
    idle_bus();
    rst_n = 1'b1;
    @(negedge clk);
    check("aborted_write_pwm_a", pwm_a, 32'd170);
    check("post_rst_brushless", {31'd0, z_brushless}, 32'd1);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
